fifo_rr_arbiter: RTL

Round-robin pop arbiter that sits directly downstream of a bank of NUM_Q input FIFOs and merges their words into one output stream feeding a single destination FIFO. Each cycle it pops at most one non-empty source, selected in cyclic order from the last source granted. One cycle later it captures that source's registered read data and issues a push with the source id. The destination's almost-full flag back-pressures all pops.

---
 rtl/fifo_rr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
// Round-robin pop arbiter that merges a bank of NUM_Q source FIFOs into one
// destination stream. Each cycle it pops at most one non-empty source, chosen
// in cyclic order after the last granted source. Two cycles after a pop, the
// source's registered read data is pushed downstream, together with its id.
//
// Ports
//   clk              : clock, rising edge
//   reset_L          : asynchronous reset, active-high (legacy name)
//   fifo_empty       : per-source empty flags, bit i = source i
//   fifo_data        : per-source registered read data, source i at [i*DATA_SIZE +: DATA_SIZE]
//   dest_almost_full : destination back-pressure, 1 = stop popping
//   pop              : one-hot-or-zero read strobe to sources (combinational)
//   push             : write strobe to destination (registered)
//   data_out         : word presented with push (registered, holds when idle)
//   src_id           : source index of data_out (registered, holds when idle)
//   active           : arbiter is in the ACTIVE state
module fifo_rr_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int NUM_Q     = 4,
  parameter int ID_W      = 2
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic [NUM_Q-1:0]           fifo_empty,
  input  logic [NUM_Q*DATA_SIZE-1:0] fifo_data,
  input  logic                       dest_almost_full,
  output logic [NUM_Q-1:0]           pop,
  output logic                       push,
  output logic [DATA_SIZE-1:0]       data_out,
  output logic [ID_W-1:0]            src_id,
  output logic                       active
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ID_W-1:0]       last_grant_r;
  logic [ID_W-1:0]       grant_s;
  logic                  grant_vld_s;
  logic [NUM_Q-1:0]      pop_s;
  logic                  pop_fire_s;
  logic                  pend_valid_r;
  logic [ID_W-1:0]       pend_id_r;
  logic [DATA_SIZE-1:0]  data_sel_s;
  logic                  push_r;
  logic [DATA_SIZE-1:0]  data_r;
  logic [ID_W-1:0]       src_id_r;

  // Round-robin search: walk offsets from NUM_Q down to 1 so the smallest
  // offset (closest to last_grant+1) overwrites the rest and wins. Offset
  // NUM_Q wraps onto last_grant itself, which is searched last. NUM_Q is a
  // power of two, so the ID_W-bit add wraps modulo NUM_Q for free.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx         = '0;
    grant_s     = last_grant_r;
    grant_vld_s = 1'b0;
    for (int k = NUM_Q; k >= 1; k--) begin
      idx         = last_grant_r + ID_W'(k);
      grant_s     = (!fifo_empty[idx]) ? idx  : grant_s;
      grant_vld_s = (!fifo_empty[idx]) ? 1'b1 : grant_vld_s;
    end
  end

  // Next-state and pop decode. Both states move toward ACTIVE exactly when
  // some source has data and the destination has room.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = '0;
    case (state_r)
      IDLE: begin
        if (grant_vld_s && !dest_almost_full) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (grant_vld_s && !dest_almost_full) begin
          pop_s[grant_s] = 1'b1;
          state_nxt_s    = ACTIVE;
        end else begin
          state_nxt_s    = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign pop_fire_s = |pop_s;

  // State, round-robin pointer and the pop->data pipeline tag.
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      state_r      <= IDLE;
      last_grant_r <= ID_W'(NUM_Q - 1);
      pend_valid_r <= 1'b0;
      pend_id_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (pop_fire_s) begin
        last_grant_r <= grant_s;
        pend_valid_r <= 1'b1;
        pend_id_r    <= grant_s;
      end else begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  // Select the registered read data of the source popped last cycle.
  always_comb begin
    data_sel_s = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      data_sel_s = (pend_id_r == ID_W'(i)) ? fifo_data[i*DATA_SIZE +: DATA_SIZE] : data_sel_s;
    end
  end

  // Output stage: capture the source word and push it; data/id hold otherwise.
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      push_r   <= 1'b0;
      data_r   <= '0;
      src_id_r <= '0;
    end else if (pend_valid_r) begin
      push_r   <= 1'b1;
      data_r   <= data_sel_s;
      src_id_r <= pend_id_r;
    end else begin
      push_r   <= 1'b0;
    end
  end

  // pop stays combinational so a source is read in the same cycle it is granted.
  assign pop      = pop_s;
  assign push     = push_r;
  assign data_out = data_r;
  assign src_id   = src_id_r;
  assign active   = (state_r == ACTIVE);

endmodule
